// File: rtl/hdu_sb.sv
`default_nettype none
// ============================================================================
// Module   : hdu_sb
// Brief    : Hazard detection unit with N-stage forwarding, late-result stalls,
//            redirect flushes, multi-cycle-unit wait state and event counters.
// Revision : 1.0
// ============================================================================
module hdu_sb #(
    parameter int NSTG = 3,
    parameter int AW   = 5,
    parameter int CW   = 6,
    parameter int PW   = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [AW-1:0]              i_rs1_id,
    input  logic [AW-1:0]              i_rs2_id,
    input  logic                       i_rs1_used,
    input  logic                       i_rs2_used,
    input  logic [NSTG*AW-1:0]         i_rd,
    input  logic [NSTG-1:0]            i_rd_wren,
    input  logic [NSTG-1:0]            i_rd_late,
    input  logic                       i_redirect,
    input  logic                       i_mc_start,
    input  logic [CW-1:0]              i_mc_lat,
    output logic [$clog2(NSTG+1)-1:0]  o_fwd_a,
    output logic [$clog2(NSTG+1)-1:0]  o_fwd_b,
    output logic                       o_en_pc,
    output logic                       o_en_if,
    output logic                       o_en_id,
    output logic                       o_en_ex,
    output logic                       o_flush_if,
    output logic                       o_flush_id,
    output logic                       o_flush_ex,
    output logic                       o_mc_busy,
    output logic [PW-1:0]              o_cnt_stall,
    output logic [PW-1:0]              o_cnt_flush,
    output logic [PW-1:0]              o_cnt_mc
);

    localparam int FW = $clog2(NSTG+1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_mc_cnt;
    logic [PW-1:0]   r_cnt_stall;
    logic [PW-1:0]   r_cnt_flush;
    logic [PW-1:0]   r_cnt_mc;

    logic [FW:0]     w_pick_a;
    logic [FW:0]     w_pick_b;
    logic            w_lh;
    logic            w_run;
    logic            w_ev_flush;
    logic            w_ev_stall;
    logic            w_mc_go;

    // Returns {late, select}; scanning from oldest to youngest lets the nearest match win.
    function automatic logic [FW:0] fwd_pick(
        input logic [AW-1:0]      rs,
        input logic               used,
        input logic [NSTG*AW-1:0] rd,
        input logic [NSTG-1:0]    wren,
        input logic [NSTG-1:0]    late
    );
        logic [FW:0] r;
        r = '0;
        if (used && (rs != '0)) begin
            for (int k = NSTG-1; k >= 0; k--) begin
                if (wren[k] && (rd[k*AW +: AW] == rs)) begin
                    r = {late[k], FW'(k+1)};
                end
            end
        end
        return r;
    endfunction

    assign w_pick_a   = fwd_pick(i_rs1_id, i_rs1_used, i_rd, i_rd_wren, i_rd_late);
    assign w_pick_b   = fwd_pick(i_rs2_id, i_rs2_used, i_rd, i_rd_wren, i_rd_late);
    assign w_lh       = w_pick_a[FW] | w_pick_b[FW];

    assign w_run      = (r_state == ST_RUN);
    assign w_ev_flush = w_run & i_redirect;
    assign w_ev_stall = w_run & ~i_redirect & w_lh;
    assign w_mc_go    = w_run & ~i_redirect & i_mc_start & (i_mc_lat > CW'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_mc_cnt    <= '0;
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
            r_cnt_mc    <= '0;
        end else begin
            if (w_ev_stall) r_cnt_stall <= r_cnt_stall + PW'(1);
            if (w_ev_flush) r_cnt_flush <= r_cnt_flush + PW'(1);
            case (r_state)
                ST_RUN: begin
                    // The issuing cycle counts as the first of i_mc_lat EX cycles.
                    if (w_mc_go) begin
                        r_mc_cnt <= i_mc_lat - CW'(1);
                        r_state  <= ST_MC_WAIT;
                    end
                end
                ST_MC_WAIT: begin
                    r_cnt_mc <= r_cnt_mc + PW'(1);
                    if (r_mc_cnt <= CW'(1)) begin
                        r_mc_cnt <= '0;
                        r_state  <= ST_RUN;
                    end else begin
                        r_mc_cnt <= r_mc_cnt - CW'(1);
                    end
                end
                default: begin
                    r_mc_cnt <= '0;
                    r_state  <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        o_fwd_a    = w_pick_a[FW-1:0];
        o_fwd_b    = w_pick_b[FW-1:0];
        o_en_pc    = 1'b1;
        o_en_if    = 1'b1;
        o_en_id    = 1'b1;
        o_en_ex    = 1'b1;
        o_flush_if = 1'b0;
        o_flush_id = 1'b0;
        o_flush_ex = 1'b0;
        if (i_reset) begin
            o_fwd_a    = '0;
            o_fwd_b    = '0;
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
        end else if (r_state == ST_MC_WAIT) begin
            o_en_pc    = 1'b0;
            o_en_if    = 1'b0;
            o_en_id    = 1'b0;
            o_en_ex    = 1'b0;
            o_flush_ex = 1'b1;
        end else if (i_redirect) begin
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
        end else if (w_lh) begin
            o_en_pc    = 1'b0;
            o_en_if    = 1'b0;
            o_en_id    = 1'b0;
            o_flush_id = 1'b1;
        end
    end

    assign o_mc_busy   = (r_state == ST_MC_WAIT);
    assign o_cnt_stall = r_cnt_stall;
    assign o_cnt_flush = r_cnt_flush;
    assign o_cnt_mc    = r_cnt_mc;

endmodule
`default_nettype wire

// File: tb/tb_hdu_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdu_sb
// Brief    : Directed and random checks of hdu_sb against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_hdu_sb;

    localparam int NSTG = 3;
    localparam int AW   = 5;
    localparam int CW   = 6;
    localparam int PW   = 32;
    localparam int FW   = 2;

    logic                 i_clk;
    logic                 i_reset;
    logic [AW-1:0]        i_rs1_id;
    logic [AW-1:0]        i_rs2_id;
    logic                 i_rs1_used;
    logic                 i_rs2_used;
    logic [NSTG*AW-1:0]   i_rd;
    logic [NSTG-1:0]      i_rd_wren;
    logic [NSTG-1:0]      i_rd_late;
    logic                 i_redirect;
    logic                 i_mc_start;
    logic [CW-1:0]        i_mc_lat;
    logic [FW-1:0]        o_fwd_a;
    logic [FW-1:0]        o_fwd_b;
    logic                 o_en_pc, o_en_if, o_en_id, o_en_ex;
    logic                 o_flush_if, o_flush_id, o_flush_ex;
    logic                 o_mc_busy;
    logic [PW-1:0]        o_cnt_stall, o_cnt_flush, o_cnt_mc;

    int                   n_checks;
    int                   n_fail;

    int                   m_busy_left;
    int unsigned          m_stall;
    int unsigned          m_flush;
    int unsigned          m_mc;

    hdu_sb #(.NSTG(NSTG), .AW(AW), .CW(CW), .PW(PW)) u_dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rs1_id    (i_rs1_id),
        .i_rs2_id    (i_rs2_id),
        .i_rs1_used  (i_rs1_used),
        .i_rs2_used  (i_rs2_used),
        .i_rd        (i_rd),
        .i_rd_wren   (i_rd_wren),
        .i_rd_late   (i_rd_late),
        .i_redirect  (i_redirect),
        .i_mc_start  (i_mc_start),
        .i_mc_lat    (i_mc_lat),
        .o_fwd_a     (o_fwd_a),
        .o_fwd_b     (o_fwd_b),
        .o_en_pc     (o_en_pc),
        .o_en_if     (o_en_if),
        .o_en_id     (o_en_id),
        .o_en_ex     (o_en_ex),
        .o_flush_if  (o_flush_if),
        .o_flush_id  (o_flush_id),
        .o_flush_ex  (o_flush_ex),
        .o_mc_busy   (o_mc_busy),
        .o_cnt_stall (o_cnt_stall),
        .o_cnt_flush (o_cnt_flush),
        .o_cnt_mc    (o_cnt_mc)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Nearest producing stage wins: scan from EX outward and stop at the first hit.
    function automatic void ref_fwd(input logic [AW-1:0] rs, input logic used,
                                    output int sel, output bit late);
        sel  = 0;
        late = 0;
        if (used && rs != 0) begin
            for (int k = 0; k < NSTG; k++) begin
                if (i_rd_wren[k] && i_rd[k*AW +: AW] == rs) begin
                    sel  = k + 1;
                    late = i_rd_late[k];
                    break;
                end
            end
        end
    endfunction

    task automatic set_rd(input int k, input logic [AW-1:0] v);
        i_rd[k*AW +: AW] = v;
    endtask

    // Compare every output against the model, then advance one clock and update the model.
    task automatic tick();
        int  ea, eb;
        bit  la, lb, lh;
        bit  e_pc, e_if, e_id, e_ex, f_if, f_id, f_ex, e_busy;
        #2;
        ref_fwd(i_rs1_id, i_rs1_used, ea, la);
        ref_fwd(i_rs2_id, i_rs2_used, eb, lb);
        lh = la | lb;
        {e_pc, e_if, e_id, e_ex} = 4'b1111;
        {f_if, f_id, f_ex}       = 3'b000;
        e_busy = 0;
        if (i_reset) begin
            ea = 0; eb = 0;
            {f_if, f_id, f_ex} = 3'b111;
        end else if (m_busy_left > 0) begin
            e_busy = 1;
            {e_pc, e_if, e_id, e_ex} = 4'b0000;
            f_ex = 1;
        end else if (i_redirect) begin
            f_if = 1; f_id = 1;
        end else if (lh) begin
            {e_pc, e_if, e_id} = 3'b000;
            f_id = 1;
        end
        chk("fwd_a",    64'(o_fwd_a), 64'(ea));
        chk("fwd_b",    64'(o_fwd_b), 64'(eb));
        chk("en_pc",    64'(o_en_pc), 64'(e_pc));
        chk("en_if",    64'(o_en_if), 64'(e_if));
        chk("en_id",    64'(o_en_id), 64'(e_id));
        chk("en_ex",    64'(o_en_ex), 64'(e_ex));
        chk("flush_if", 64'(o_flush_if), 64'(f_if));
        chk("flush_id", 64'(o_flush_id), 64'(f_id));
        chk("flush_ex", 64'(o_flush_ex), 64'(f_ex));
        chk("mc_busy",  64'(o_mc_busy), 64'(e_busy));
        chk("cnt_stall", 64'(o_cnt_stall), i_reset ? 64'd0 : 64'(m_stall));
        chk("cnt_flush", 64'(o_cnt_flush), i_reset ? 64'd0 : 64'(m_flush));
        chk("cnt_mc",    64'(o_cnt_mc),    i_reset ? 64'd0 : 64'(m_mc));
        @(posedge i_clk);
        if (i_reset) begin
            m_busy_left = 0;
            m_stall = 0; m_flush = 0; m_mc = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            m_mc++;
        end else begin
            if (i_redirect)  m_flush++;
            else if (lh)     m_stall++;
            if (i_mc_start && i_mc_lat > 1 && !i_redirect) m_busy_left = int'(i_mc_lat) - 1;
        end
        #1;
    endtask

    task automatic quiet();
        i_rs1_id = '0; i_rs2_id = '0; i_rs1_used = 0; i_rs2_used = 0;
        i_rd = '0; i_rd_wren = '0; i_rd_late = '0;
        i_redirect = 0; i_mc_start = 0; i_mc_lat = '0;
    endtask

    initial begin
        int unsigned s0, f0, c0;
        int          nb;
        n_checks = 0; n_fail = 0;
        m_busy_left = 0; m_stall = 0; m_flush = 0; m_mc = 0;
        quiet();
        i_reset = 1;
        @(posedge i_clk); #1;
        tick();
        i_reset = 0;
        tick();

        // Forward priority across stages
        i_rs1_id = 5; i_rs1_used = 1;
        for (int k = 0; k < NSTG; k++) set_rd(k, 5);
        i_rd_wren = 3'b111;
        #1 chk("fp_ex", 64'(o_fwd_a), 64'd1);
        tick();
        i_rd_wren = 3'b110;
        #1 chk("fp_mem", 64'(o_fwd_a), 64'd2);
        tick();
        i_rs1_id = 0;
        #1 chk("fp_x0", 64'(o_fwd_a), 64'd0);
        tick();

        // Unused rs2 never forwards or stalls
        quiet();
        i_rs2_id = 7; set_rd(0, 7); i_rd_wren = 3'b001; i_rd_late = 3'b001;
        #1 chk("rs2_unused_fwd", 64'(o_fwd_b), 64'd0);
        chk("rs2_unused_en", 64'(o_en_pc), 64'd1);
        tick();

        // Load-use stall then forward from MEM
        quiet();
        s0 = o_cnt_stall;
        i_rs1_id = 3; i_rs1_used = 1; set_rd(0, 3); i_rd_wren = 3'b001; i_rd_late = 3'b001;
        #1 chk("lu_en_pc", 64'(o_en_pc), 64'd0);
        chk("lu_flush_id", 64'(o_flush_id), 64'd1);
        tick();
        set_rd(0, 0); set_rd(1, 3); i_rd_wren = 3'b010; i_rd_late = 3'b000;
        #1 chk("lu_fwd_mem", 64'(o_fwd_a), 64'd2);
        chk("lu_en_after", 64'(o_en_pc), 64'd1);
        chk("lu_cnt_stall", 64'(o_cnt_stall), 64'(s0 + 1));
        tick();

        // Redirect overrides load-use
        s0 = o_cnt_stall; f0 = o_cnt_flush;
        set_rd(0, 3); i_rd_wren = 3'b001; i_rd_late = 3'b001; i_redirect = 1;
        #1 chk("rd_flush_if", 64'(o_flush_if), 64'd1);
        chk("rd_en_pc", 64'(o_en_pc), 64'd1);
        tick();
        quiet();
        #1 chk("rd_cnt_stall", 64'(o_cnt_stall), 64'(s0));
        chk("rd_cnt_flush", 64'(o_cnt_flush), 64'(f0 + 1));
        tick();

        // MCU latency 4: three wait cycles
        c0 = o_cnt_mc;
        i_mc_start = 1; i_mc_lat = 4;
        tick();
        quiet();
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_mc_busy) nb++;
            tick();
        end
        chk("mc_busy_cycles", 64'(nb), 64'd3);
        chk("mc_cnt", 64'(o_cnt_mc), 64'(c0 + 3));

        // Latency 1 is single-cycle; redirect drops an MCU op
        i_mc_start = 1; i_mc_lat = 1;
        tick();
        quiet();
        #1 chk("mc_lat1_busy", 64'(o_mc_busy), 64'd0);
        tick();
        i_mc_start = 1; i_mc_lat = 5; i_redirect = 1;
        tick();
        quiet();
        #1 chk("mc_redirect_drop", 64'(o_mc_busy), 64'd0);
        tick();

        // Asynchronous reset in the middle of a wait
        i_mc_start = 1; i_mc_lat = 5;
        tick();
        quiet();
        tick();
        i_reset = 1;
        #1 chk("ar_busy", 64'(o_mc_busy), 64'd0);
        chk("ar_cnt_mc", 64'(o_cnt_mc), 64'd0);
        chk("ar_cnt_flush", 64'(o_cnt_flush), 64'd0);
        chk("ar_flush", 64'({o_flush_if, o_flush_id, o_flush_ex}), 64'd7);
        tick();
        i_reset = 0;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            i_rs1_id   = AW'($urandom_range(0, 3));
            i_rs2_id   = AW'($urandom_range(0, 3));
            i_rs1_used = 1'($urandom_range(0, 3) != 0);
            i_rs2_used = 1'($urandom_range(0, 1));
            for (int k = 0; k < NSTG; k++) set_rd(k, AW'($urandom_range(0, 3)));
            i_rd_wren  = NSTG'($urandom);
            i_rd_late  = NSTG'($urandom_range(0, 7) & $urandom_range(0, 7));
            i_redirect = 1'($urandom_range(0, 5) == 0);
            i_mc_start = 1'($urandom_range(0, 7) == 0);
            i_mc_lat   = CW'($urandom_range(0, 6));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
